leaf_out_scheduler: RTL
=======================

Name: leaf_out_scheduler

Overview:
- Credit-aware, round-robin scheduler that shares one outbound BFT packet slot between NUM_STREAMS user output streams of a leaf.
- Each stream uses a 32-bit ap_vld/ap_ack handshake, the same as HLS operator outputs.
- The granted word is tagged with a per-stream destination (leaf, port) from a runtime config table and registered as one packet toward the leaf interface.
- Per-stream credit counters stop a stream from overrunning its downstream buffer.

Parameters:
- NUM_STREAMS, 4, number of user output streams (2..8).
- PAYLOAD_BITS, 32, payload width.
- PACKET_BITS, 49, outbound packet width.
- NUM_LEAF_BITS, 3, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- CREDIT_BITS, 8, credit counter width.
- CREDIT_INIT, 64, credits loaded per stream at reset.

Ports:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-low reset.
- din_user, in, NUM_STREAMS*PAYLOAD_BITS, stream payloads; stream i occupies slice i.
- vld_user, in, NUM_STREAMS, stream valid.
- ack_user, out, NUM_STREAMS, stream accept (combinational).
- pkt_out, out, PACKET_BITS, registered outbound packet.
- pkt_vld, out, 1, pkt_out holds a packet.
- pkt_rdy, in, 1, downstream accepts the packet.
- cr_ret_vld, in, 1, credit return strobe.
- cr_ret_id, in, 3, stream receiving credits.
- cr_ret_cnt, in, CREDIT_BITS, credits returned.
- cfg_wr, in, 1, config table write strobe.
- cfg_idx, in, 3, stream index to configure.
- cfg_leaf, in, NUM_LEAF_BITS, destination leaf.
- cfg_port, in, NUM_PORT_BITS, destination port.
- cfg_en, in, 1, stream enable.
- stall_cnt, out, 16, count of credit-blocked cycles (only with SCHED_STATS_EN; otherwise tied to 0).

Behaviour:
- Reset (reset=0, asynchronous):
  - pkt_vld=0, pkt_out=0, ack_user=0.
  - Every credit counter = CREDIT_INIT.
  - Config table all zero, all streams disabled.
  - Round-robin pointer = 0; stall_cnt = 0.
- Eligibility: stream i is eligible when vld_user[i]=1, en[i]=1 and credit[i]!=0.
- Load condition: load = (pkt_vld==0) or (pkt_vld & pkt_rdy).
  - The slot can be drained and refilled in the same cycle, sustaining 1 packet/cycle.
- Arbitration:
  - When load=1 and at least one stream is eligible, grant the first eligible stream searching from ptr, wrapping modulo NUM_STREAMS.
  - ack_user[grant]=1 in that same cycle. All other ack bits stay 0, and ack_user is always 0 when load=0.
  - At the clock edge, pkt_out is captured, pkt_vld=1, and ptr becomes grant+1 (wrapping).
  - Word-to-packet latency is 1 cycle.
- Packet format:
  - pkt_out = {zero pad, 1'b1, leaf[i], port[i], payload}.
  - With default parameters the valid marker is bit 39; bits 48..40 are 0.
- Drain without refill: pkt_vld & pkt_rdy with nothing eligible makes pkt_vld=0 next cycle; pkt_out holds its last value.
- Backpressure: pkt_vld=1 and pkt_rdy=0 means pkt_out is stable, no ack is issued and ptr is frozen.
- Credits:
  - A grant decrements credit[i] by 1.
  - cr_ret_vld adds cr_ret_cnt to credit[cr_ret_id].
  - A grant and a return on the same stream in the same cycle apply net (credit - 1 + cnt).
  - Credits saturate at 2^CREDIT_BITS-1.
  - cr_ret_id >= NUM_STREAMS is ignored.
  - A stream with zero credits is skipped by the arbiter and never acked.
- Config:
  - cfg_wr writes leaf, port and en for cfg_idx at the edge and takes effect from the next arbitration cycle.
  - A packet already captured keeps its old destination.
  - cfg_idx >= NUM_STREAMS is ignored.
  - Disabling a stream with vld high leaves that stream un-acked; its data is not dropped.
- Config and credit return may occur in the same cycle without interaction.

Optional Feature:
- SCHED_STATS_EN defined:
  - stall_cnt increments by 1 every cycle in which some stream has vld=1 and en=1 but credit=0.
  - Saturates at 16'hFFFF; cleared by reset only.
- SCHED_STATS_EN undefined:
  - stall_cnt is tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset state: reset low for 3 cycles, then high. Require pkt_vld=0, ack_user=0 and credit[0..3]=64 (checked via 64 consecutive grants on stream 0 before it blocks).
- Round robin: streams 0-3 enabled, all vld=1 continuously, pkt_rdy=1. Require grants in order 0,1,2,3,0,…, one packet per cycle, and pkt_out payload/leaf/port matching each stream's config (e.g., stream 2 with leaf=5, port=3 gives pkt_out[38:32]=7'b101_0011).
- Backpressure: pkt_rdy=0 for 5 cycles while all vld=1. Require pkt_out stable, ack_user=0, and on release the next grant resumes at ptr.
- Credit exhaustion: stream 1 only, CREDIT_INIT=64, pkt_rdy=1. Require exactly 64 acks, then none; cr_ret_vld with id=1, cnt=2 yields exactly 2 more acks. With SCHED_STATS_EN, stall_cnt increments each blocked cycle.
- Simultaneous events: grant on stream 3 plus cr_ret id=3, cnt=5 in the same cycle gives credit +4. cfg_wr disabling stream 3 while its vld=1 gives no further acks on stream 3, and the other streams continue.
- Mid-operation reset: assert reset while pkt_vld=1 and credits partially consumed. Require an immediate pkt_vld=0 and all credits back to 64 after release.

Source files
------------

// File: rtl/leaf_out_scheduler_if.sv
// rtl/leaf_out_scheduler_if.sv - stream, packet, credit and config signals of the leaf output scheduler
// master: scheduler side; slave: user streams, leaf interface and config source.
interface leaf_out_scheduler_if #(
  parameter int NUM_STREAMS   = 4,
  parameter int PAYLOAD_BITS  = 32,
  parameter int PACKET_BITS   = 49,
  parameter int NUM_LEAF_BITS = 3,
  parameter int NUM_PORT_BITS = 4,
  parameter int CREDIT_BITS   = 8
);
  logic [NUM_STREAMS*PAYLOAD_BITS-1:0] din_user;
  logic [NUM_STREAMS-1:0]              vld_user;
  logic [NUM_STREAMS-1:0]              ack_user;
  logic [PACKET_BITS-1:0]              pkt_out;
  logic                                pkt_vld;
  logic                                pkt_rdy;
  logic                                cr_ret_vld;
  logic [2:0]                          cr_ret_id;
  logic [CREDIT_BITS-1:0]              cr_ret_cnt;
  logic                                cfg_wr;
  logic [2:0]                          cfg_idx;
  logic [NUM_LEAF_BITS-1:0]            cfg_leaf;
  logic [NUM_PORT_BITS-1:0]            cfg_port;
  logic                                cfg_en;
  logic [15:0]                         stall_cnt;

  modport master (
    input  din_user, vld_user, pkt_rdy, cr_ret_vld, cr_ret_id, cr_ret_cnt,
           cfg_wr, cfg_idx, cfg_leaf, cfg_port, cfg_en,
    output ack_user, pkt_out, pkt_vld, stall_cnt
  );

  modport slave (
    output din_user, vld_user, pkt_rdy, cr_ret_vld, cr_ret_id, cr_ret_cnt,
           cfg_wr, cfg_idx, cfg_leaf, cfg_port, cfg_en,
    input  ack_user, pkt_out, pkt_vld, stall_cnt
  );
endinterface

// File: rtl/leaf_out_scheduler.sv
// rtl/leaf_out_scheduler.sv - credit-aware round-robin scheduler of user streams onto one BFT packet slot
// Optional stall statistics counter is built only when SCHED_STATS_EN is defined.
module leaf_out_scheduler #(
  parameter int NUM_STREAMS   = 4,
  parameter int PAYLOAD_BITS  = 32,
  parameter int PACKET_BITS   = 49,
  parameter int NUM_LEAF_BITS = 3,
  parameter int NUM_PORT_BITS = 4,
  parameter int CREDIT_BITS   = 8,
  parameter int CREDIT_INIT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  leaf_out_scheduler_if.master bus
);

  localparam int PTR_W    = $clog2(NUM_STREAMS);
  localparam int PAD_BITS = PACKET_BITS - PAYLOAD_BITS - NUM_LEAF_BITS - NUM_PORT_BITS - 1;
  localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = '1;

  logic [CREDIT_BITS-1:0]   credit_q [NUM_STREAMS];
  logic [CREDIT_BITS-1:0]   credit_d [NUM_STREAMS];
  logic [NUM_LEAF_BITS-1:0] leaf_q   [NUM_STREAMS];
  logic [NUM_PORT_BITS-1:0] port_q   [NUM_STREAMS];
  logic [NUM_STREAMS-1:0]   en_q;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic                     pkt_vld_q, pkt_vld_d;
  logic [PACKET_BITS-1:0]   pkt_q, pkt_d;

  logic [NUM_STREAMS-1:0]   elig;
  logic [NUM_STREAMS-1:0]   ack;
  logic [PTR_W-1:0]         gnt;
  logic                     found;
  logic                     load;
  logic [PAYLOAD_BITS-1:0]  payload;

  always_comb begin
    for (int i = 0; i < NUM_STREAMS; i++) begin
      elig[i] = bus.vld_user[i] & en_q[i] & (credit_q[i] != '0);
    end
  end

  // The slot may be refilled in the same cycle it drains.
  assign load = !pkt_vld_q || bus.pkt_rdy;

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gnt   = '0;
    for (int k = 0; k < NUM_STREAMS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_STREAMS) idx = idx - NUM_STREAMS;
      if (!found && elig[PTR_W'(idx)]) begin
        found = 1'b1;
        gnt   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    ack = '0;
    if (load && found) ack[gnt] = 1'b1;
  end

  assign bus.ack_user = ack;
  assign payload      = bus.din_user[int'(gnt)*PAYLOAD_BITS +: PAYLOAD_BITS];

  always_comb begin
    pkt_vld_d = pkt_vld_q;
    pkt_d     = pkt_q;
    ptr_d     = ptr_q;
    if (load) begin
      pkt_vld_d = found;
      if (found) begin
        pkt_d = {{PAD_BITS{1'b0}}, 1'b1, leaf_q[gnt], port_q[gnt], payload};
        ptr_d = (int'(gnt) == NUM_STREAMS - 1) ? '0 : gnt + 1'b1;
      end
    end
  end

  // Grant and return on one stream apply as a single net update, then saturate.
  always_comb begin
    logic [CREDIT_BITS:0] sum;
    sum = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      sum = {1'b0, credit_q[i]};
      if (bus.cr_ret_vld && bus.cr_ret_id == 3'(i)) sum = sum + {1'b0, bus.cr_ret_cnt};
      if (ack[i]) sum = sum - 1'b1;
      credit_d[i] = sum[CREDIT_BITS] ? CREDIT_MAX : sum[CREDIT_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_vld_q <= 1'b0;
      pkt_q     <= '0;
      ptr_q     <= '0;
      en_q      <= '0;
      for (int i = 0; i < NUM_STREAMS; i++) begin
        credit_q[i] <= CREDIT_BITS'(CREDIT_INIT);
        leaf_q[i]   <= '0;
        port_q[i]   <= '0;
      end
    end else begin
      pkt_vld_q <= pkt_vld_d;
      pkt_q     <= pkt_d;
      ptr_q     <= ptr_d;
      for (int i = 0; i < NUM_STREAMS; i++) begin
        credit_q[i] <= credit_d[i];
        if (bus.cfg_wr && bus.cfg_idx == 3'(i)) begin
          leaf_q[i] <= bus.cfg_leaf;
          port_q[i] <= bus.cfg_port;
          en_q[i]   <= bus.cfg_en;
        end
      end
    end
  end

  assign bus.pkt_vld = pkt_vld_q;
  assign bus.pkt_out = pkt_q;

`ifdef SCHED_STATS_EN
  logic [NUM_STREAMS-1:0] blocked;
  logic [15:0]            stall_q;

  always_comb begin
    for (int i = 0; i < NUM_STREAMS; i++) begin
      blocked[i] = bus.vld_user[i] & en_q[i] & (credit_q[i] == '0);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if ((|blocked) && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule
